// File: rtl/arbitros_pkg.sv
// Shared definitions for the class-based arbiters (merger arbitro_1 and the splitter).
// Class tags are CLASS_W bits wide on both sides of the fabric.
package arbitros_pkg;

    localparam int unsigned NUM_VC  = 4;
    localparam int unsigned CLASS_W = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POP  = 2'd1;
    localparam logic [1:0] ST_PUSH = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_POP  = ST_POP,
        S_PUSH = ST_PUSH
    } state_t;

endpackage

// File: rtl/arbitro_pick.sv
// Combinational grant picker for arbitro_1.
// ARBITRO_1_ROUND_ROBIN_EN selects round-robin from ptr; otherwise fixed priority (VC0 highest).
module arbitro_pick
    import arbitros_pkg::*;
(
    input  logic [NUM_VC-1:0]  req,
    input  logic [CLASS_W-1:0] ptr,
    output logic [CLASS_W-1:0] gnt_idx,
    output logic               gnt_valid
);

`ifdef ARBITRO_1_ROUND_ROBIN_EN
    logic [CLASS_W-1:0] idx;

    // Index arithmetic is CLASS_W bits wide, so the search wraps 3->0 naturally.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_VC; k++) begin
            idx = ptr + CLASS_W'(k);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_VC; k++) begin
            if (!gnt_valid && req[k]) begin
                gnt_valid = 1'b1;
                gnt_idx   = CLASS_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/arbitro_1.sv
// Merges four per-class FWFT FIFOs into one tagged output FIFO, one word per POP/PUSH pair.
// Build option: define ARBITRO_1_ROUND_ROBIN_EN for round-robin, else fixed priority.
module arbitro_1
    import arbitros_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_VC-1:0]            FIFO_empty,
    input  logic [NUM_VC*DATA_WIDTH-1:0] data_in,
    input  logic                         Almost_full,
    output logic [NUM_VC-1:0]            Pop,
    output logic                         Push,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic [CLASS_W-1:0]           class_out
);

    if (ADDR_WIDTH < 1) begin : g_addr_width_check
        $error("arbitro_1: ADDR_WIDTH must be at least 1");
    end

    state_t               state_q;
    logic [CLASS_W-1:0]   gnt_q;
    logic [NUM_VC-1:0]    pop_q;
    logic                 push_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CLASS_W-1:0]   class_q;
    logic [CLASS_W-1:0]   pick_ptr;
    logic [CLASS_W-1:0]   gnt_idx;
    logic                 gnt_valid;
    logic                 grant_hit;

`ifdef ARBITRO_1_ROUND_ROBIN_EN
    logic [CLASS_W-1:0]   rr_ptr_q;
    assign pick_ptr = rr_ptr_q;
`else
    assign pick_ptr = '0;
`endif

    arbitro_pick u_pick (
        .req       (~FIFO_empty),
        .ptr       (pick_ptr),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Almost_full only gates new grants; a word already popped is always pushed.
    assign grant_hit = gnt_valid && !Almost_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            pop_q    <= '0;
            push_q   <= 1'b0;
            data_q   <= '0;
            class_q  <= '0;
`ifdef ARBITRO_1_ROUND_ROBIN_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_PUSH: begin
                    push_q <= 1'b0;
                    if (grant_hit) begin
                        pop_q   <= NUM_VC'(1) << gnt_idx;
                        gnt_q   <= gnt_idx;
                        state_q <= S_POP;
`ifdef ARBITRO_1_ROUND_ROBIN_EN
                        rr_ptr_q <= gnt_idx + CLASS_W'(1);
`endif
                    end else begin
                        pop_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                S_POP: begin
                    pop_q   <= '0;
                    push_q  <= 1'b1;
                    data_q  <= data_in[gnt_q*DATA_WIDTH +: DATA_WIDTH];
                    class_q <= gnt_q;
                    state_q <= S_PUSH;
                end
                default: begin
                    pop_q   <= '0;
                    push_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Pop       = pop_q;
    assign Push      = push_q;
    assign data_out  = data_q;
    assign class_out = class_q;

endmodule

// File: tb/tb_arbitro_1.sv
// Self-checking bench for arbitro_1: directed literal checks plus a per-cycle transaction model.
module tb_arbitro_1;

    logic        clk;
    logic        reset;
    logic [3:0]  FIFO_empty;
    logic [31:0] data_in;
    logic        Almost_full;
    logic [3:0]  Pop;
    logic        Push;
    logic [7:0]  data_out;
    logic [1:0]  class_out;

    int n_cmp = 0;
    int n_bad = 0;

    arbitro_1 #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .FIFO_empty  (FIFO_empty),
        .data_in     (data_in),
        .Almost_full (Almost_full),
        .Pop         (Pop),
        .Push        (Push),
        .data_out    (data_out),
        .class_out   (class_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Transaction model: a grant produces a pop, and the popped head is pushed one cycle later.
    function automatic int model_pick(input logic [3:0] req, input int ptr);
        int idx;
        for (int k = 0; k < 4; k++) begin
`ifdef ARBITRO_1_ROUND_ROBIN_EN
            idx = (ptr + k) % 4;
`else
            idx = k;
`endif
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    logic [3:0] m_pop  = '0;
    logic       m_push = 1'b0;
    logic [7:0] m_data = '0;
    logic [1:0] m_cls  = '0;
    int         m_gnt  = 0;
    int         m_ptr  = 0;

    always @(posedge clk or posedge reset) begin
        int g;
        if (reset) begin
            m_pop  <= '0;
            m_push <= 1'b0;
            m_data <= '0;
            m_cls  <= '0;
            m_ptr  <= 0;
        end else if (m_pop != 4'd0) begin
            m_data <= data_in[m_gnt*8 +: 8];
            m_cls  <= 2'(m_gnt);
            m_push <= 1'b1;
            m_pop  <= '0;
        end else begin
            m_push <= 1'b0;
            g = model_pick(~FIFO_empty, m_ptr);
            if (!Almost_full && g >= 0) begin
                m_pop <= 4'b0001 << g;
                m_gnt <= g;
                m_ptr <= (g + 1) % 4;
            end else begin
                m_pop <= '0;
            end
        end
    end

    always @(negedge clk) begin
        check("model_pop",   32'(Pop),       32'(m_pop));
        check("model_push",  32'(Push),      32'(m_push));
        check("model_data",  32'(data_out),  32'(m_data));
        check("model_class", 32'(class_out), 32'(m_cls));
        check("pop_onehot0", 32'($onehot0(Pop)), 32'd1);
        check("pop_push_overlap", 32'((|Pop) && Push), 32'd0);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cls;
        reset       = 1'b1;
        FIFO_empty  = 4'b1111;
        data_in     = '0;
        Almost_full = 1'b0;
        step(3);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step(1);
            check("idle_pop",  32'(Pop),  32'd0);
            check("idle_push", 32'(Push), 32'd0);
        end
        check("reset_data",  32'(data_out),  32'd0);
        check("reset_class", 32'(class_out), 32'd0);

        data_in    = {8'h13, 8'h12, 8'h11, 8'h10};
        FIFO_empty = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (k % 2 == 0) begin
`ifdef ARBITRO_1_ROUND_ROBIN_EN
                exp_cls = (k / 2 - 1) % 4;
`else
                exp_cls = 0;
`endif
                check("all4_push",  32'(Push),      32'd1);
                check("all4_class", 32'(class_out), 32'(exp_cls));
                check("all4_data",  32'(data_out),  32'h10 + 32'(exp_cls));
            end else begin
                check("all4_gap", 32'(Push), 32'd0);
            end
        end
        FIFO_empty = 4'b1111;
        step(4);

        data_in       = '0;
        data_in[15:8] = 8'hA5;
        FIFO_empty    = 4'b1101;
        step(1);
        check("vc1_pop",  32'(Pop),  32'b0010);
        check("vc1_nopush", 32'(Push), 32'd0);
        FIFO_empty = 4'b1111;
        step(1);
        check("vc1_push",  32'(Push),      32'd1);
        check("vc1_data",  32'(data_out),  32'hA5);
        check("vc1_class", 32'(class_out), 32'd1);
        check("vc1_popoff", 32'(Pop),      32'd0);
        step(2);

        data_in[7:0] = 8'h3C;
        Almost_full  = 1'b1;
        FIFO_empty   = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("af_nopop", 32'(Pop), 32'd0);
        end
        Almost_full = 1'b0;
        step(1);
        check("af_release_pop", 32'(Pop), 32'b0001);
        Almost_full = 1'b1;
        step(1);
        check("af_inflight_push", 32'(Push),     32'd1);
        check("af_inflight_data", 32'(data_out), 32'h3C);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("af_hold_pop",  32'(Pop),  32'd0);
            check("af_hold_push", 32'(Push), 32'd0);
        end

        Almost_full = 1'b0;
        step(1);
        check("rst_pre_pop", 32'(Pop), 32'b0001);
        #2 reset = 1'b1;
        #1;
        check("rst_async_pop",   32'(Pop),       32'd0);
        check("rst_async_push",  32'(Push),      32'd0);
        check("rst_async_data",  32'(data_out),  32'd0);
        check("rst_async_class", 32'(class_out), 32'd0);
        step(1);
        check("rst_held_push", 32'(Push), 32'd0);
        reset = 1'b0;
        step(1);
        check("rst_restart_pop", 32'(Pop), 32'b0001);
        step(1);
        check("rst_restart_push", 32'(Push),     32'd1);
        check("rst_restart_data", 32'(data_out), 32'h3C);
        FIFO_empty = 4'b1111;
        step(2);

        for (int i = 0; i < 1000; i++) begin
            FIFO_empty  = 4'($urandom);
            data_in     = $urandom;
            Almost_full = ($urandom_range(0, 3) == 0);
            step(1);
        end
        FIFO_empty  = 4'b1111;
        Almost_full = 1'b0;
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
